pixel_write_arbiter: RTL and testbench

Round-robin arbiter that shares the single Avalon-MM write path into the 640x480, 16-bit VGA pixel buffer between several FPGA-side drawing requesters (e.g. the cursor renderer driven by the HPS X/Y coordinate PIOs and the sprite/line engines). Each requester presents one pixel as (x, y, colour). The block grants one requester at a time, converts the coordinates to a pixel-buffer byte address, and issues one 16-bit Avalon write, honouring waitrequest. Out-of-range pixels are consumed and dropped. Write and drop counters are exposed for debug.

---
 rtl/pixel_write_arbiter.sv | 138 +++++++++++++
 tb/tb_pixel_write_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pixel_write_arbiter.sv
// pixel_write_arbiter
//
// Round-robin arbiter sharing one Avalon-MM write path into a 640x480, 16-bit
// pixel buffer between NUM_REQ drawing requesters. A granted pixel is either
// converted to a byte address and written, or dropped when out of range.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   req_valid/ready   per-requester handshake (ready is one-hot or zero)
//   req_x/y/color     packed per-requester pixel (10/9/16 bits per requester)
//   avm_*             Avalon-MM write master (address, write, writedata,
//                     byteenable, waitrequest)
//   busy              high while a write is outstanding
//   pix_count         completed writes, wraps
//   drop_count        clipped pixels, saturates at 16'hFFFF

module pixel_write_arbiter #(
    parameter int unsigned NUM_REQ   = 2,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned H_RES     = 640,
    parameter int unsigned V_RES     = 480
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [10*NUM_REQ-1:0] req_x,
    input  logic [9*NUM_REQ-1:0]  req_y,
    input  logic [16*NUM_REQ-1:0] req_color,
    output logic [31:0]           avm_address,
    output logic                  avm_write,
    output logic [15:0]           avm_writedata,
    output logic [1:0]            avm_byteenable,
    input  logic                  avm_waitrequest,
    output logic                  busy,
    output logic [31:0]           pix_count,
    output logic [15:0]           drop_count
);

    localparam int unsigned GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [0:0] {StIdle, StWrite} state_e;

    state_e          state_q, state_d;
    logic [GW-1:0]   last_grant_q, last_grant_d;
    logic [31:0]     addr_q, addr_d;
    logic [15:0]     data_q, data_d;
    logic [31:0]     pix_q, pix_d;
    logic [15:0]     drop_q, drop_d;

    logic            grant_found;
    logic [GW-1:0]   grant_idx;
    int unsigned     cand;
    logic [9:0]      sel_x;
    logic [8:0]      sel_y;
    logic [15:0]     sel_color;
    logic            in_range;

    // Rotating priority: scan starts one past the last winner.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = last_grant_q;
        cand        = 0;
        for (int off = 1; off <= int'(NUM_REQ); off++) begin
            cand = (int'(last_grant_q) + off) % NUM_REQ;
            if (!grant_found && req_valid[cand[GW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[GW-1:0];
            end
        end
    end

    assign sel_x     = req_x[10*grant_idx +: 10];
    assign sel_y     = req_y[9*grant_idx +: 9];
    assign sel_color = req_color[16*grant_idx +: 16];
    assign in_range  = ({22'd0, sel_x} < H_RES) && ({23'd0, sel_y} < V_RES);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        data_d       = data_q;
        pix_d        = pix_q;
        drop_d       = drop_q;
        req_ready    = '0;

        unique case (state_q)
            StIdle: begin
                if (grant_found && !reset) begin
                    req_ready[grant_idx] = 1'b1;
                    last_grant_d         = grant_idx;
                    if (in_range) begin
                        addr_d  = BASE_ADDR + ({23'd0, sel_y} << 11) + ({22'd0, sel_x} << 1);
                        data_d  = sel_color;
                        state_d = StWrite;
                    end else if (drop_q != 16'hFFFF) begin
                        drop_d = drop_q + 16'd1;
                    end
                end
            end
            StWrite: begin
                if (!avm_waitrequest) begin
                    pix_d   = pix_q + 32'd1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            last_grant_q <= GW'(NUM_REQ - 1);
            addr_q       <= '0;
            data_q       <= '0;
            pix_q        <= '0;
            drop_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            pix_q        <= pix_d;
            drop_q       <= drop_d;
        end
    end

    // Write strobe and busy both follow the registered state.
    assign avm_write      = (state_q == StWrite);
    assign busy           = (state_q == StWrite);
    assign avm_address    = addr_q;
    assign avm_writedata  = data_q;
    assign avm_byteenable = 2'b11;
    assign pix_count      = pix_q;
    assign drop_count     = drop_q;

endmodule

// File: tb/tb_pixel_write_arbiter.sv
module tb_pixel_write_arbiter;

    localparam int unsigned NUM_REQ = 2;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [10*NUM_REQ-1:0] req_x;
    logic [9*NUM_REQ-1:0]  req_y;
    logic [16*NUM_REQ-1:0] req_color;
    logic [31:0]           avm_address;
    logic                  avm_write;
    logic [15:0]           avm_writedata;
    logic [1:0]            avm_byteenable;
    logic                  avm_waitrequest;
    logic                  busy;
    logic [31:0]           pix_count;
    logic [15:0]           drop_count;

    int checks = 0;
    int errors = 0;

    pixel_write_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .BASE_ADDR(32'h0000_0000),
        .H_RES    (640),
        .V_RES    (480)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_x          (req_x),
        .req_y          (req_y),
        .req_color      (req_color),
        .avm_address    (avm_address),
        .avm_write      (avm_write),
        .avm_writedata  (avm_writedata),
        .avm_byteenable (avm_byteenable),
        .avm_waitrequest(avm_waitrequest),
        .busy           (busy),
        .pix_count      (pix_count),
        .drop_count     (drop_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_pix(input int r, input logic [9:0] x, input logic [8:0] y,
                           input logic [15:0] c);
        req_x[10*r +: 10] = x;
        req_y[9*r +: 9]   = y;
        req_color[16*r +: 16] = c;
    endtask

    // Inputs change and outputs are sampled just after the falling edge.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    initial begin
        reset           = 1'b1;
        req_valid       = '0;
        req_x           = '0;
        req_y           = '0;
        req_color       = '0;
        avm_waitrequest = 1'b0;

        // Reset: ready must stay low even with a valid request.
        step();
        req_valid = 2'b01;
        #1;
        check_eq("ready_in_reset", 32'(req_ready), 32'h0);
        req_valid = '0;
        step();
        reset = 1'b0;
        #1;
        check_eq("rst_write", 32'(avm_write), 32'h0);
        check_eq("rst_addr", avm_address, 32'h0);
        check_eq("rst_data", 32'(avm_writedata), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        check_eq("rst_pix", pix_count, 32'h0);
        check_eq("rst_drop", 32'(drop_count), 32'h0);

        // Single write (5,3) -> 3*2048 + 5*2 = 0x180A.
        set_pix(0, 10'd5, 9'd3, 16'hF800);
        req_valid = 2'b01;
        #1;
        check_eq("single_ready", 32'(req_ready), 32'h1);
        step();
        req_valid = '0;
        #1;
        check_eq("single_write", 32'(avm_write), 32'h1);
        check_eq("single_addr", avm_address, 32'h0000_180A);
        check_eq("single_data", 32'(avm_writedata), 32'hF800);
        check_eq("single_be", 32'(avm_byteenable), 32'h3);
        check_eq("single_busy", 32'(busy), 32'h1);
        step();
        check_eq("single_write_end", 32'(avm_write), 32'h0);
        check_eq("single_pix", pix_count, 32'd1);

        // Stall: 4 waitrequest cycles stretch the write to 5 cycles.
        req_valid = 2'b01;
        #1;
        check_eq("stall_ready", 32'(req_ready), 32'h1);
        step();
        req_valid       = 2'b10;
        avm_waitrequest = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k == 4) begin
                avm_waitrequest = 1'b0;
                req_valid       = '0;
            end
            #1;
            check_eq($sformatf("stall_write%0d", k), 32'(avm_write), 32'h1);
            check_eq($sformatf("stall_addr%0d", k), avm_address, 32'h0000_180A);
            check_eq($sformatf("stall_data%0d", k), 32'(avm_writedata), 32'hF800);
            check_eq($sformatf("stall_ready%0d", k), 32'(req_ready), 32'h0);
            step();
        end
        check_eq("stall_write_end", 32'(avm_write), 32'h0);
        check_eq("stall_pix", pix_count, 32'd2);

        // Clipping: x=640 and y=480 are accepted and dropped.
        set_pix(0, 10'd640, 9'd0, 16'h1234);
        req_valid = 2'b01;
        #1;
        check_eq("clip_x_ready", 32'(req_ready), 32'h1);
        step();
        check_eq("clip_x_nowrite", 32'(avm_write), 32'h0);
        check_eq("clip_x_drop", 32'(drop_count), 32'd1);
        set_pix(0, 10'd0, 9'd480, 16'h1234);
        #1;
        check_eq("clip_y_ready", 32'(req_ready), 32'h1);
        step();
        check_eq("clip_y_nowrite", 32'(avm_write), 32'h0);
        check_eq("clip_y_drop", 32'(drop_count), 32'd2);
        check_eq("clip_pix", pix_count, 32'd2);

        // Corner (639,479): 479*2048 + 639*2 = 0xEF800 + 0x4FE = 0xEFCFE.
        set_pix(0, 10'd639, 9'd479, 16'h07E0);
        #1;
        check_eq("corner_ready", 32'(req_ready), 32'h1);
        step();
        req_valid = '0;
        #1;
        check_eq("corner_write", 32'(avm_write), 32'h1);
        check_eq("corner_addr", avm_address, 32'h000E_FCFE);
        check_eq("corner_data", 32'(avm_writedata), 32'h07E0);
        step();
        check_eq("corner_pix", pix_count, 32'd3);

        // Reset during a stalled write.
        set_pix(0, 10'd5, 9'd3, 16'hF800);
        req_valid = 2'b01;
        step();
        req_valid       = '0;
        avm_waitrequest = 1'b1;
        step();
        check_eq("midrst_write_before", 32'(avm_write), 32'h1);
        reset = 1'b1;
        step();
        reset           = 1'b0;
        avm_waitrequest = 1'b0;
        #1;
        check_eq("midrst_write", 32'(avm_write), 32'h0);
        check_eq("midrst_busy", 32'(busy), 32'h0);
        check_eq("midrst_pix", pix_count, 32'h0);
        check_eq("midrst_drop", 32'(drop_count), 32'h0);

        // Round robin with both valid: grants 0,1,0,1,0,1, one write per 2 cycles.
        set_pix(0, 10'd10, 9'd0, 16'hAAAA);
        set_pix(1, 10'd20, 9'd1, 16'h5555);
        req_valid = 2'b11;
        for (int i = 0; i < 6; i++) begin
            #1;
            check_eq($sformatf("rr_ready%0d", i), 32'(req_ready),
                     (i % 2 == 0) ? 32'h1 : 32'h2);
            step();
            check_eq($sformatf("rr_write%0d", i), 32'(avm_write), 32'h1);
            check_eq($sformatf("rr_data%0d", i), 32'(avm_writedata),
                     (i % 2 == 0) ? 32'hAAAA : 32'h5555);
            check_eq($sformatf("rr_addr%0d", i), avm_address,
                     (i % 2 == 0) ? 32'h0000_0014 : 32'h0000_0828);
            check_eq($sformatf("rr_wready%0d", i), 32'(req_ready), 32'h0);
            step();
        end
        req_valid = '0;
        #1;
        check_eq("rr_pix", pix_count, 32'd6);

        // Drop saturation: one drop per cycle from zero.
        set_pix(0, 10'd1023, 9'd0, 16'h0000);
        req_valid = 2'b01;
        repeat (65534) @(negedge clk);
        #1;
        check_eq("sat_drop_fffe", 32'(drop_count), 32'h0000_FFFE);
        repeat (5) @(negedge clk);
        #1;
        check_eq("sat_drop_ffff", 32'(drop_count), 32'h0000_FFFF);
        check_eq("sat_pix", pix_count, 32'd6);
        check_eq("sat_nowrite", 32'(avm_write), 32'h0);
        req_valid = '0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
